// File: rtl/pat_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pat_pkg
//  Purpose  : Shared opcodes, condition codes, FSM state type and
//             instruction field offsets for the pattern core.
//  Revision : 1.0 - initial release
// ============================================================================
package pat_pkg;

   // Instruction field offsets: {fieldp_next, cond[1:0], field_op, op8[3:0], imm8}
   localparam int IMM_LSB  = 0;
   localparam int OP8_LSB  = 8;
   localparam int FOP_BIT  = 12;
   localparam int COND_LSB = 13;
   localparam int FP_LSB   = 15;

   // i8 opcode space
   localparam logic [3:0] OP_BF    = 4'h0;
   localparam logic [3:0] OP_BB    = 4'h1;
   localparam logic [3:0] OP_CALL  = 4'h2;
   localparam logic [3:0] OP_LDI   = 4'h3;
   localparam logic [3:0] OP_LDM   = 4'h4;
   localparam logic [3:0] OP_STM   = 4'h5;
   localparam logic [3:0] OP_SETSP = 4'h6;
   localparam logic [3:0] OP_OR    = 4'h8;
   localparam logic [3:0] OP_AND   = 4'h9;
   localparam logic [3:0] OP_ADDM  = 4'hA;
   localparam logic [3:0] OP_SUBM  = 4'hB;
   localparam logic [3:0] OP_ADD   = 4'hC;
   localparam logic [3:0] OP_SUB   = 4'hD;
   localparam logic [3:0] OP_I3    = 4'hF;

   // i3 opcode space (imm8[6:3])
   localparam logic [3:0] OP3_SHL    = 4'h0;
   localparam logic [3:0] OP3_SHR    = 4'h1;
   localparam logic [3:0] OP3_ASHR   = 4'h2;
   localparam logic [3:0] OP3_INCSP  = 4'h3;
   localparam logic [3:0] OP3_DECSP  = 4'h4;
   localparam logic [3:0] OP3_SETBUF = 4'h5;
   localparam logic [3:0] OP3_I0     = 4'hF;

   // i0 opcode space (imm8[2:0])
   localparam logic [2:0] OP0_NOT  = 3'd0;
   localparam logic [2:0] OP0_RET  = 3'd1;
   localparam logic [2:0] OP0_NOP  = 3'd2;
   localparam logic [2:0] OP0_HALT = 3'd3;

   // Condition codes
   localparam logic [1:0] COND_ALWAYS = 2'b00;
   localparam logic [1:0] COND_Z      = 2'b01;
   localparam logic [1:0] COND_NZ     = 2'b10;
   localparam logic [1:0] COND_N      = 2'b11;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/pat_call_stack.sv
`default_nettype none
// ============================================================================
//  Module   : pat_call_stack
//  Purpose  : Bounded LIFO of return addresses; push ignored when full,
//             pop ignored when empty (the core faults on those cases).
//  Revision : 1.0 - initial release
// ============================================================================
module pat_call_stack #(
   parameter int STACK_DEPTH = 8,
   parameter int I_ADR_WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [I_ADR_WIDTH-1:0] din,
   output logic [I_ADR_WIDTH-1:0] dout,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(STACK_DEPTH);

   logic [PTR_W:0]           cnt_q, cnt_d;
   logic [I_ADR_WIDTH-1:0]   mem_q [STACK_DEPTH];
   logic [PTR_W-1:0]         wr_idx, top_idx;

   assign wr_idx  = cnt_q[PTR_W-1:0];
   assign top_idx = wr_idx - PTR_W'(1);
   assign full    = (cnt_q == (PTR_W+1)'(STACK_DEPTH));
   assign empty   = (cnt_q == '0);
   assign dout    = mem_q[top_idx];

   // Occupancy count moves on accepted push or pop
   always_comb begin
      cnt_d = cnt_q;
      if (push && !full)
         cnt_d = cnt_q + (PTR_W+1)'(1);
      else if (pop && !empty)
         cnt_d = cnt_q - (PTR_W+1)'(1);
   end

   // Occupancy register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // Entry storage; contents are irrelevant while unoccupied
   always_ff @(posedge clk) begin
      if (push && !full) mem_q[wr_idx] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/pat_core.sv
`default_nettype none
// ============================================================================
//  Module   : pat_core
//  Purpose  : Single-issue accumulator core running pattern programs from
//             instruction ROM against internal dmem and an external field
//             buffer, with conditional execution, call stack and HALT/FAULT.
//  Revision : 1.0 - initial release
// ============================================================================
module pat_core import pat_pkg::*; #(
   parameter int   D_WIDTH      = 8,
   parameter int   I_ADR_WIDTH  = 10,
   parameter int   D_ADR_WIDTH  = 8,
   parameter int   STACK_DEPTH  = 8,
   parameter int   FIELDP_WIDTH = 5,
   parameter int   BUFP_WIDTH   = 3,
   localparam int  I_WIDTH      = FIELDP_WIDTH + FP_LSB
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [I_WIDTH-1:0]      imem_in,
   input  logic [D_WIDTH-1:0]      field_in,
   output logic [I_ADR_WIDTH-1:0]  pc,
   output logic                    write_en,
   output logic [D_ADR_WIDTH-1:0]  data_adr,
   output logic [D_WIDTH-1:0]      data_out,
   output logic [BUFP_WIDTH-1:0]   bufp,
   output logic [FIELDP_WIDTH-1:0] fieldp,
   output logic [FIELDP_WIDTH-1:0] fieldwp,
   output logic [D_WIDTH-1:0]      field_out,
   output logic                    field_we,
   output logic                    halted,
   output logic                    fault
);

   // Instruction fields
   logic [FIELDP_WIDTH-1:0] fp_next;
   logic [1:0]              cond;
   logic                    fop;
   logic [3:0]              op8, op3;
   logic [7:0]              imm8;
   logic [2:0]              imm3;
   assign fp_next = imem_in[I_WIDTH-1:FP_LSB];
   assign cond    = imem_in[COND_LSB +: 2];
   assign fop     = imem_in[FOP_BIT];
   assign op8     = imem_in[OP8_LSB +: 4];
   assign imm8    = imem_in[IMM_LSB +: 8];
   assign op3     = imm8[6:3];
   assign imm3    = imm8[2:0];

   // Architectural state
   state_e                  state_q, state_d;
   logic [I_ADR_WIDTH-1:0]  pc_q, pc_d;
   logic [D_WIDTH-1:0]      acc_q, acc_d;
   logic [D_ADR_WIDTH-1:0]  sp_q, sp_d;
   logic                    z_q, z_d, n_q, n_d;
   logic [BUFP_WIDTH-1:0]   bufp_q, bufp_d;
   logic [FIELDP_WIDTH-1:0] fieldp_q, fieldp_d, fieldwp_q, fieldwp_d;
   logic [D_WIDTH-1:0]      field_out_q, field_out_d, data_out_q, data_out_d;
   logic                    field_we_q, field_we_d, write_en_q, write_en_d;
   logic [D_ADR_WIDTH-1:0]  data_adr_q, data_adr_d;

   logic [D_WIDTH-1:0]      dmem_q [2**D_ADR_WIDTH];
   logic                    dmem_we;

   logic                    stk_push, stk_pop, stk_full, stk_empty;
   logic [I_ADR_WIDTH-1:0]  stk_dout;

   // Datapath helpers
   logic [D_WIDTH-1:0]      imm_d, operand, mem_rd, res;
   logic [I_ADR_WIDTH-1:0]  imm_pc, pc_inc;
   logic [D_ADR_WIDTH-1:0]  adr;
   logic                    cond_ok, has_res, go_fault, go_halt;

   assign imm_d   = D_WIDTH'(imm8);
   assign imm_pc  = I_ADR_WIDTH'(imm8);
   assign adr     = D_ADR_WIDTH'(imm8);
   assign pc_inc  = pc_q + I_ADR_WIDTH'(1);
   assign operand = fop ? field_in : acc_q;
   assign mem_rd  = dmem_q[adr];

   pat_call_stack #(
      .STACK_DEPTH (STACK_DEPTH),
      .I_ADR_WIDTH (I_ADR_WIDTH)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (stk_push),
      .pop   (stk_pop),
      .din   (pc_inc),
      .dout  (stk_dout),
      .full  (stk_full),
      .empty (stk_empty)
   );

   // Condition evaluation against the current flags
   always_comb begin
      cond_ok = 1'b1;
      case (cond)
         COND_Z:  cond_ok = z_q;
         COND_NZ: cond_ok = !z_q;
         COND_N:  cond_ok = n_q;
         default: cond_ok = 1'b1;
      endcase
   end

   // Decode, ALU and next-state computation
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      acc_d       = acc_q;
      sp_d        = sp_q;
      z_d         = z_q;
      n_d         = n_q;
      bufp_d      = bufp_q;
      fieldp_d    = fieldp_q;
      fieldwp_d   = fieldwp_q;
      field_out_d = field_out_q;
      field_we_d  = 1'b0;
      write_en_d  = 1'b0;
      data_adr_d  = data_adr_q;
      data_out_d  = data_out_q;
      dmem_we     = 1'b0;
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      res         = '0;
      has_res     = 1'b0;
      go_fault    = 1'b0;
      go_halt     = 1'b0;

      if (state_q == ST_RUN) begin
         fieldp_d = fp_next;
         pc_d     = pc_inc;
         if (cond_ok) begin
            case (op8)
               OP_BF:    pc_d = pc_q + imm_pc;
               OP_BB:    pc_d = pc_q - imm_pc;
               OP_CALL: begin
                  if (stk_full) go_fault = 1'b1;
                  else begin
                     stk_push = 1'b1;
                     pc_d     = pc_q + imm_pc;
                  end
               end
               OP_LDI:   begin res = imm_d;               has_res = 1'b1; end
               OP_LDM:   begin res = mem_rd;              has_res = 1'b1; end
               OP_STM: begin
                  dmem_we    = 1'b1;
                  write_en_d = 1'b1;
                  data_adr_d = adr;
                  data_out_d = operand;
               end
               OP_SETSP: sp_d = adr;
               OP_OR:    begin res = operand | imm_d;     has_res = 1'b1; end
               OP_AND:   begin res = operand & imm_d;     has_res = 1'b1; end
               OP_ADDM:  begin res = operand + mem_rd;    has_res = 1'b1; end
               OP_SUBM:  begin res = operand - mem_rd;    has_res = 1'b1; end
               OP_ADD:   begin res = operand + imm_d;     has_res = 1'b1; end
               OP_SUB:   begin res = operand - imm_d;     has_res = 1'b1; end
               OP_I3: begin
                  case (op3)
                     OP3_SHL:    begin res = operand << imm3;            has_res = 1'b1; end
                     OP3_SHR:    begin res = operand >> imm3;            has_res = 1'b1; end
                     OP3_ASHR:   begin res = $signed(operand) >>> imm3;  has_res = 1'b1; end
                     OP3_INCSP:  sp_d   = sp_q + D_ADR_WIDTH'(1);
                     OP3_DECSP:  sp_d   = sp_q - D_ADR_WIDTH'(1);
                     OP3_SETBUF: bufp_d = BUFP_WIDTH'(imm3);
                     OP3_I0: begin
                        case (imm3)
                           OP0_NOT:  begin res = ~operand; has_res = 1'b1; end
                           OP0_RET: begin
                              if (stk_empty) go_fault = 1'b1;
                              else begin
                                 stk_pop = 1'b1;
                                 pc_d    = stk_dout;
                              end
                           end
                           OP0_NOP:  pc_d    = pc_inc;
                           OP0_HALT: go_halt = 1'b1;
                           default:  go_fault = 1'b1;
                        endcase
                     end
                     default: go_fault = 1'b1;
                  endcase
               end
               default: go_fault = 1'b1;
            endcase

            // Results land in the field buffer or the accumulator; only the
            // accumulator path updates flags.
            if (has_res) begin
               if (fop) begin
                  field_out_d = res;
                  field_we_d  = 1'b1;
                  fieldwp_d   = fieldp_q;
               end else begin
                  acc_d = res;
                  z_d   = (res == '0);
                  n_d   = res[D_WIDTH-1];
               end
            end

            // Terminal transitions freeze pc at the offending instruction
            if (go_fault) begin
               state_d = ST_FAULT;
               pc_d    = pc_q;
            end else if (go_halt) begin
               state_d = ST_HALT;
               pc_d    = pc_q;
            end
         end
      end
   end

   // Architectural registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         pc_q        <= '0;
         acc_q       <= '0;
         sp_q        <= '0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         bufp_q      <= '0;
         fieldp_q    <= '0;
         fieldwp_q   <= '0;
         field_out_q <= '0;
         field_we_q  <= 1'b0;
         write_en_q  <= 1'b0;
         data_adr_q  <= '0;
         data_out_q  <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         acc_q       <= acc_d;
         sp_q        <= sp_d;
         z_q         <= z_d;
         n_q         <= n_d;
         bufp_q      <= bufp_d;
         fieldp_q    <= fieldp_d;
         fieldwp_q   <= fieldwp_d;
         field_out_q <= field_out_d;
         field_we_q  <= field_we_d;
         write_en_q  <= write_en_d;
         data_adr_q  <= data_adr_d;
         data_out_q  <= data_out_d;
      end
   end

   // Internal data memory; contents survive reset
   always_ff @(posedge clk) begin
      if (dmem_we) dmem_q[adr] <= operand;
   end

   assign pc        = pc_q;
   assign write_en  = write_en_q;
   assign data_adr  = data_adr_q;
   assign data_out  = data_out_q;
   assign bufp      = bufp_q;
   assign fieldp    = fieldp_q;
   assign fieldwp   = fieldwp_q;
   assign field_out = field_out_q;
   assign field_we  = field_we_q;
   assign halted    = (state_q == ST_HALT);
   assign fault     = (state_q == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_pat_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pat_core
//  Purpose  : Directed self-checking bench for pat_core with a scoreboard
//             queue of expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pat_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [19:0] imem_in;
   logic [7:0]  field_in;
   logic [9:0]  pc;
   logic        write_en;
   logic [7:0]  data_adr, data_out;
   logic [2:0]  bufp;
   logic [4:0]  fieldp, fieldwp;
   logic [7:0]  field_out;
   logic        field_we, halted, fault;

   logic [19:0] prog [0:1023];

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign imem_in  = prog[pc];
   assign field_in = 8'h40 | {3'b000, fieldp};

   pat_core dut (
      .clk       (clk),
      .rst       (rst),
      .imem_in   (imem_in),
      .field_in  (field_in),
      .pc        (pc),
      .write_en  (write_en),
      .data_adr  (data_adr),
      .data_out  (data_out),
      .bufp      (bufp),
      .fieldp    (fieldp),
      .fieldwp   (fieldwp),
      .field_out (field_out),
      .field_we  (field_we),
      .halted    (halted),
      .fault     (fault)
   );

   function automatic logic [19:0] enc(input logic [4:0] fpn, input logic [1:0] c,
                                       input logic fo, input logic [3:0] op,
                                       input logic [7:0] imm);
      return {fpn, c, fo, op, imm};
   endfunction

   localparam logic [7:0] I_NOP  = 8'h7A;
   localparam logic [7:0] I_RET  = 8'h79;
   localparam logic [7:0] I_HALT = 8'h7B;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      n_assert++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 1024; i++) prog[i] = enc(5'd0, 2'b00, 1'b0, 4'hF, I_NOP);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // ---- Reset mid-program ----
      clear_prog();
      prog[0] = enc(5'd3, 2'b00, 1'b0, 4'hF, 8'h2D);          // setbuf 5
      for (int i = 1; i < 6; i++) prog[i] = enc(5'd3, 2'b00, 1'b0, 4'hF, I_NOP);
      prog[6] = enc(5'd3, 2'b00, 1'b1, 4'h3, 8'h11);          // field ldi 0x11
      do_reset();
      expect_val("reset_pc0", 0);          chk(pc);
      tick(7);
      expect_val("pre_pc7", 7);            chk(pc);
      expect_val("pre_bufp", 5);           chk(bufp);
      expect_val("pre_field_we", 1);       chk(field_we);
      expect_val("pre_fieldwp", 3);        chk(fieldwp);
      rst = 1'b1;
      #1;
      expect_val("rst_pc", 0);             chk(pc);
      expect_val("rst_bufp", 0);           chk(bufp);
      expect_val("rst_field_we", 0);       chk(field_we);
      expect_val("rst_fieldwp", 0);        chk(fieldwp);
      expect_val("rst_field_out", 0);      chk(field_out);
      expect_val("rst_fieldp", 0);         chk(fieldp);
      @(negedge clk);
      rst = 1'b0;
      expect_val("rel_pc0", 0);            chk(pc);
      tick(1);
      expect_val("rel_pc1", 1);            chk(pc);
      tick(1);
      expect_val("rel_pc2", 2);            chk(pc);

      // ---- Z-conditional branch taken ----
      clear_prog();
      prog[0] = enc(5'd0, 2'b00, 1'b0, 4'h3, 8'h05);          // ldi 5
      prog[1] = enc(5'd0, 2'b00, 1'b0, 4'hD, 8'h05);          // sub 5
      prog[2] = enc(5'd0, 2'b01, 1'b0, 4'h0, 8'h03);          // Z bf 3
      prog[5] = enc(5'd0, 2'b00, 1'b0, 4'h5, 8'h20);          // stm 0x20
      do_reset();
      tick(3);
      expect_val("bfz_pc", 5);             chk(pc);
      tick(1);
      expect_val("bfz_we", 1);             chk(write_en);
      expect_val("bfz_acc", 0);            chk(data_out);
      expect_val("bfz_adr", 8'h20);        chk(data_adr);

      // ---- !Z branch not taken ----
      prog[2] = enc(5'd0, 2'b10, 1'b0, 4'h0, 8'h03);
      do_reset();
      tick(3);
      expect_val("bfnz_pc", 3);            chk(pc);

      // ---- Field writes ----
      clear_prog();
      prog[0] = enc(5'd4, 2'b00, 1'b0, 4'hF, I_NOP);
      prog[1] = enc(5'd2, 2'b00, 1'b1, 4'h3, 8'hAA);          // field ldi 0xAA
      prog[2] = enc(5'd0, 2'b00, 1'b1, 4'hC, 8'h01);          // field add 1
      do_reset();
      tick(1);
      expect_val("fld_fieldp", 4);         chk(fieldp);
      tick(1);
      expect_val("fld_we", 1);             chk(field_we);
      expect_val("fld_out", 8'hAA);        chk(field_out);
      expect_val("fld_wp", 4);             chk(fieldwp);
      tick(1);
      expect_val("fld_add_out", 8'h43);    chk(field_out);
      expect_val("fld_add_wp", 2);         chk(fieldwp);
      tick(1);
      expect_val("fld_we_pulse", 0);       chk(field_we);

      // ---- Nested calls overflow ----
      clear_prog();
      for (int i = 0; i < 9; i++) prog[i] = enc(5'd0, 2'b00, 1'b0, 4'h2, 8'h01);
      do_reset();
      tick(8);
      expect_val("call8_pc", 8);           chk(pc);
      expect_val("call8_fault", 0);        chk(fault);
      tick(1);
      expect_val("call9_fault", 1);        chk(fault);
      expect_val("call9_halted", 0);       chk(halted);
      expect_val("call9_pc", 8);           chk(pc);
      tick(2);
      expect_val("call9_pc_frozen", 8);    chk(pc);

      // ---- Call / return ----
      clear_prog();
      prog[0] = enc(5'd0, 2'b00, 1'b0, 4'h2, 8'h04);          // call +4
      prog[4] = enc(5'd0, 2'b00, 1'b0, 4'hF, I_RET);
      do_reset();
      tick(1);
      expect_val("call_pc", 4);            chk(pc);
      tick(1);
      expect_val("ret_pc", 1);             chk(pc);
      expect_val("ret_fault", 0);          chk(fault);

      // ---- Return on empty stack ----
      clear_prog();
      prog[0] = enc(5'd0, 2'b00, 1'b0, 4'hF, I_RET);
      do_reset();
      tick(1);
      expect_val("ret_empty_fault", 1);    chk(fault);
      expect_val("ret_empty_pc", 0);       chk(pc);

      // ---- Store / load forwarding ----
      clear_prog();
      prog[0] = enc(5'd0, 2'b00, 1'b0, 4'h3, 8'h3C);          // ldi 0x3C
      prog[1] = enc(5'd0, 2'b00, 1'b0, 4'h5, 8'h10);          // stm 0x10
      prog[2] = enc(5'd0, 2'b00, 1'b0, 4'h3, 8'h00);          // ldi 0
      prog[3] = enc(5'd0, 2'b00, 1'b0, 4'h4, 8'h10);          // ldm 0x10
      prog[4] = enc(5'd0, 2'b00, 1'b0, 4'h5, 8'h11);          // stm 0x11
      do_reset();
      tick(2);
      expect_val("stm_we", 1);             chk(write_en);
      expect_val("stm_adr", 8'h10);        chk(data_adr);
      expect_val("stm_data", 8'h3C);       chk(data_out);
      tick(1);
      expect_val("stm_we_pulse", 0);       chk(write_en);
      tick(2);
      expect_val("ldm_we", 1);             chk(write_en);
      expect_val("ldm_adr", 8'h11);        chk(data_adr);
      expect_val("ldm_acc", 8'h3C);        chk(data_out);

      // ---- Arithmetic shift, N flag, illegal op ----
      clear_prog();
      prog[0] = enc(5'd0, 2'b00, 1'b0, 4'h3, 8'h80);          // ldi 0x80
      prog[1] = enc(5'd0, 2'b00, 1'b0, 4'hF, 8'h11);          // ashr 1
      prog[2] = enc(5'd0, 2'b00, 1'b0, 4'h5, 8'h30);          // stm 0x30
      prog[3] = enc(5'd0, 2'b11, 1'b0, 4'h0, 8'h04);          // N bf 4
      prog[7] = enc(5'd0, 2'b00, 1'b0, 4'h7, 8'h00);          // illegal
      do_reset();
      tick(3);
      expect_val("ashr_acc", 8'hC0);       chk(data_out);
      tick(1);
      expect_val("bfn_pc", 7);             chk(pc);
      tick(1);
      expect_val("illegal_fault", 1);      chk(fault);
      expect_val("illegal_halted", 0);     chk(halted);
      expect_val("illegal_pc", 7);         chk(pc);

      // ---- Halt ----
      clear_prog();
      prog[0] = enc(5'd0, 2'b00, 1'b0, 4'hF, I_HALT);
      do_reset();
      tick(1);
      expect_val("halt_halted", 1);        chk(halted);
      expect_val("halt_fault", 0);         chk(fault);
      tick(2);
      expect_val("halt_pc", 0);            chk(pc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pat_core.md
# pat_core

Parametrised successor of the 8-bit pattern processor: a single-issue, one-instruction-per-cycle accumulator core that executes pattern programs from instruction memory against an internal data memory and an external field buffer. Over the previous generation it adds:
- configurable widths and depths;
- real conditional execution with Z/N flags;
- decoded i3/i0 instruction spaces;
- a bounded call stack with fault detection;
- HALT/FAULT states;
- explicit field write strobes.

It sits between the instruction ROM and the pattern/field buffer.

## Interface
- D_WIDTH, 8: accumulator/data width (>= 8); 8-bit immediates are zero-extended
- I_ADR_WIDTH, 10: instruction address width
- D_ADR_WIDTH, 8: internal dmem address width (depth 2**D_ADR_WIDTH); immediate addresses truncated to this
- STACK_DEPTH, 8: call stack entries (power of two)
- FIELDP_WIDTH, 5: field pointer width
- BUFP_WIDTH, 3: buffer select width
- I_WIDTH, FIELDP_WIDTH+15: derived instruction width; not overridden

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- imem_in  in  I_WIDTH  instruction at pc, combinational from ROM
- field_in  in  D_WIDTH  field value addressed by fieldp
- pc  out  I_ADR_WIDTH  program counter
- write_en  out  1  registered dmem write mirror strobe
- data_adr  out  D_ADR_WIDTH  address of mirrored write
- data_out  out  D_WIDTH  data of mirrored write
- bufp  out  BUFP_WIDTH  buffer select
- fieldp  out  FIELDP_WIDTH  field read pointer
- fieldwp  out  FIELDP_WIDTH  field write pointer
- field_out  out  D_WIDTH  field write data
- field_we  out  1  field write strobe
- halted  out  1  core in HALT
- fault  out  1  core in FAULT

## Operation
- Encoding, MSB first: {fieldp_next, cond[1:0], field_op, op8[3:0], imm8}.
- op8 values:
  - 0 bf: pc+=imm
  - 1 bb: pc-=imm
  - 2 call
  - 3 ldi
  - 4 ldm
  - 5 stm
  - 6 setsp
  - 8 or
  - 9 and
  - A addm
  - B subm
  - C add
  - D sub
  - 7, E: illegal -> FAULT
  - F: i3 space
- i3 space, op3=imm8[6:3], imm3=imm8[2:0]:
  - 0 shl
  - 1 shr
  - 2 ashr
  - 3 incsp
  - 4 decsp
  - 5 setbuf (bufp<=imm3)
  - F: i0 space
  - other: FAULT
- i0 space, op0=imm8[2:0]:
  - 0 not
  - 1 ret
  - 2 nop
  - 3 halt
  - other: FAULT
- cond:
  - 00 always
  - 01 Z
  - 10 !Z
  - 11 N
- Failed condition: pc+1 only. Flags, memory, stack and field outputs are unchanged; fieldp still updates.
- Operand source:
  - field_op=0: operand is acc, result goes to acc.
  - field_op=1: operand is field_in, result goes to field_out with field_we=1 and fieldwp<=fieldp (current register value).
- Z/N track every acc write: Z = (result==0), N = result MSB. Field ops leave flags unchanged.
- Arithmetic is modulo 2**D_WIDTH. ashr is signed on D_WIDTH.
- fieldp<=fieldp_next every RUN cycle. Instruction N therefore operates on the field addressed by instruction N-1.
- call:
  - pushes pc+1, pc+=imm.
  - With STACK_DEPTH entries already used -> FAULT, no push.
- ret:
  - pops into pc.
  - On an empty stack -> FAULT.
- pc wraps modulo 2**I_ADR_WIDTH.
- stm:
  - writes internal dmem (acc or field_in).
  - Next cycle write_en=1 with data_adr/data_out; otherwise write_en=0.
- ldm/addm/subm read dmem asynchronously. An stm followed by ldm of the same address returns the new value.
- FSM:
  - RUN: executes.
  - RUN -> HALT on halt.
  - RUN -> FAULT on illegal op or stack error.
  - HALT and FAULT are terminal until rst. pc freezes at the offending instruction and all strobes are 0.

## Timing
- One instruction per clk.
- Registered outputs update on the posedge that retires the instruction.
- field_we and write_en are single-cycle pulses.
- Reset (asynchronous, any time, including mid-call) sets:
  - 0: pc, acc, sp, stack pointer, flags, bufp, fieldp, fieldwp, field_out, field_we, write_en, data_adr, data_out, halted, fault
  - state RUN
  - dmem contents are not reset.
- First fetch is at pc=0 on the first posedge after rst deasserts.

## Structure
- Package pat_pkg holds:
  - opcode constants for the i8/i3/i0 spaces
  - condition codes
  - the FSM state enum
  - the I_WIDTH field-offset helper constants
- Sub-module pat_call_stack holds the LIFO:
  - parameters STACK_DEPTH and I_ADR_WIDTH
  - ports push, pop, din, dout, full, empty
  - synchronous with the same asynchronous reset
- The decode, ALU and FSM stay in pat_core.

## Test plan
- Reset mid-program: assert rst while pc=7 -> all outputs 0 immediately; after release, pc sequence is 0,1,2.
- ldi 0x05, sub 5, cond=01 bf 3 -> acc=0, Z=1, branch taken; pc goes 2 -> 5. Repeating with cond=10 -> pc=3.
- field_op ldi 0xAA with previous fieldp_next=4 -> field_we pulse, field_out=0xAA, fieldwp=4.
- Nine nested calls with STACK_DEPTH=8 -> eighth call succeeds, ninth asserts fault and pc freezes. ret on an empty stack from reset also gives fault.
- ldi 0x3C; stm 0x10; ldi 0; ldm 0x10 -> write_en=1, data_adr=0x10, data_out=0x3C one cycle after stm; acc=0x3C.
- ldi 0x80; ashr 1 with D_WIDTH=8 -> acc=0xC0, N=1. An illegal op8=7 -> fault=1 and halted=0.
